// File: rtl/cpu_run_pkg.sv
// Shared state encoding and default widths for the run/load sequencer.
package cpu_run_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 16;

  // Codes are shown directly on the 7-segment display.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    RUN        = 3'd2,
    STEP_LEAVE = 3'd3,
    STEP_WAIT  = 3'd4,
    HALTED     = 3'd5,
    RESTART    = 3'd6
  } run_state_e;

endpackage

// File: rtl/key_edge.sv
// Key conditioner: 2-FF synchroniser, optional debounce (KEY_DEBOUNCE_EN), registered rising-edge pulse.
module key_edge #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

`ifdef KEY_DEBOUNCE_EN
  localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'((DB_CYCLES < 1) ? 0 : DB_CYCLES - 1);

  logic [CW-1:0] r_db_cnt;
  logic          r_level;

  // Down-counter restarts whenever the synchronised level agrees with the accepted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt <= RELOAD;
      r_level  <= 1'b0;
    end else if (r_sync2 == r_level) begin
      r_db_cnt <= RELOAD;
    end else if (r_db_cnt == '0) begin
      r_level  <= r_sync2;
      r_db_cnt <= RELOAD;
    end else begin
      r_db_cnt <= r_db_cnt - 1'b1;
    end
  end

  assign w_level = r_level;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      o_pulse <= 1'b0;
    end else begin
      r_prev  <= w_level;
      o_pulse <= w_level & ~r_prev;
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/load sequencer for the accumulator processor; define KEY_DEBOUNCE_EN to debounce the keys.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int DB_CYCLES = 500000
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              key_load,
  input  logic              key_write,
  input  logic              key_start,
  input  logic              key_step,
  input  logic [DATA_W-1:0] sw_data,
  input  logic              Halt,
  input  logic              fetch_state,
  output logic              cpu_en,
  output logic              cpu_rst_n,
  output logic              mem_sel,
  output logic              ld_we,
  output logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic [2:0]        mode,
  output logic [CNT_W-1:0]  instr_count
);

  logic       w_p_load, w_p_write, w_p_start, w_p_step;
  logic       w_load, w_write, w_start, w_step;
  logic       w_write_go, w_load_entry;
  run_state_e r_state, w_next;
  logic       r_fetch_d;

  key_edge #(.DB_CYCLES(DB_CYCLES)) u_key_load  (.clk(CLOCK_50), .rst_n(reset), .i_key(key_load),  .o_pulse(w_p_load));
  key_edge #(.DB_CYCLES(DB_CYCLES)) u_key_write (.clk(CLOCK_50), .rst_n(reset), .i_key(key_write), .o_pulse(w_p_write));
  key_edge #(.DB_CYCLES(DB_CYCLES)) u_key_start (.clk(CLOCK_50), .rst_n(reset), .i_key(key_start), .o_pulse(w_p_start));
  key_edge #(.DB_CYCLES(DB_CYCLES)) u_key_step  (.clk(CLOCK_50), .rst_n(reset), .i_key(key_step),  .o_pulse(w_p_step));

  // Only the highest-priority pulse of a cycle survives: load > start > step > write.
  assign w_load  = w_p_load;
  assign w_start = w_p_start & ~w_p_load;
  assign w_step  = w_p_step  & ~w_p_load & ~w_p_start;
  assign w_write = w_p_write & ~w_p_load & ~w_p_start & ~w_p_step;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_load)       w_next = LOAD;
        else if (w_start) w_next = RUN;
        else if (w_step)  w_next = STEP_LEAVE;
      end
      LOAD:       if (w_load) w_next = IDLE;
      RUN: begin
        if (Halt)         w_next = HALTED;
        else if (w_start) w_next = IDLE;
      end
      STEP_LEAVE: begin
        if (Halt)              w_next = HALTED;
        else if (!fetch_state) w_next = STEP_WAIT;
      end
      STEP_WAIT: begin
        if (Halt)             w_next = HALTED;
        else if (fetch_state) w_next = IDLE;
      end
      HALTED: begin
        if (w_load)       w_next = LOAD;
        else if (w_start) w_next = RESTART;
      end
      RESTART:    w_next = RUN;
      default:    w_next = IDLE;
    endcase
  end

  assign w_write_go   = (r_state == LOAD) && (w_next == LOAD) && w_write;
  assign w_load_entry = (r_state != LOAD) && (w_next == LOAD);

  // Outputs are registered from the next state so they change together with the state.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_fetch_d   <= 1'b0;
      mode        <= IDLE;
      cpu_en      <= 1'b0;
      cpu_rst_n   <= 1'b0;
      mem_sel     <= 1'b0;
      ld_we       <= 1'b0;
      ld_addr     <= '0;
      ld_data     <= '0;
      instr_count <= '0;
    end else begin
      r_state   <= w_next;
      r_fetch_d <= fetch_state;
      mode      <= w_next;
      cpu_en    <= (w_next == RUN) || (w_next == STEP_LEAVE) || (w_next == STEP_WAIT);
      cpu_rst_n <= !((w_next == LOAD) || (w_next == RESTART));
      mem_sel   <= (w_next == LOAD);
      ld_we     <= w_write_go;
      if (w_write_go) ld_data <= sw_data;

      if (w_load_entry)  ld_addr <= '0;
      else if (ld_we)    ld_addr <= ld_addr + 1'b1;

      if (w_load_entry || (w_next == RESTART))
        instr_count <= '0;
      else if (fetch_state && !r_fetch_d && cpu_en && (instr_count != {CNT_W{1'b1}}))
        instr_count <= instr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl; loader writes go through an expected-write queue.
module tb_cpu_run_ctrl;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic              CLOCK_50 = 1'b0;
  logic              reset = 1'b1;
  logic              key_load = 1'b0, key_write = 1'b0, key_start = 1'b0, key_step = 1'b0;
  logic [DATA_W-1:0] sw_data = '0;
  logic              Halt = 1'b0, fetch_state = 1'b0;
  logic              cpu_en, cpu_rst_n, mem_sel, ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [2:0]        mode;
  logic [CNT_W-1:0]  instr_count;

  cpu_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .DB_CYCLES(4)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .key_load(key_load), .key_write(key_write), .key_start(key_start), .key_step(key_step),
    .sw_data(sw_data), .Halt(Halt), .fetch_state(fetch_state),
    .cpu_en(cpu_en), .cpu_rst_n(cpu_rst_n), .mem_sel(mem_sel),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .mode(mode), .instr_count(instr_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               sb[$];
  wr_t               sb_e;
  logic [ADDR_W-1:0] m_addr = '0;
  logic              prev_we = 1'b0;

  always @(negedge CLOCK_50) begin
    if (ld_we) begin
      chk("we_1cyc", 32'(prev_we), 32'd0);
      if (sb.size() == 0) begin
        chk("we_unexp", 32'(ld_we), 32'd0);
      end else begin
        sb_e = sb.pop_front();
        chk("ld_addr", 32'(ld_addr), 32'(sb_e.addr));
        chk("ld_data", 32'(ld_data), 32'(sb_e.data));
      end
    end
    prev_we <= ld_we;
  end

  task automatic set_key(input int k, input logic v);
    case (k)
      0: key_load  = v;
      1: key_write = v;
      2: key_start = v;
      default: key_step = v;
    endcase
  endtask

  // Raises a key and returns at the negedge after the pulse has taken effect.
  task automatic hit(input int k);
    @(negedge CLOCK_50);
    set_key(k, 1'b1);
    repeat (4) @(negedge CLOCK_50);
    set_key(k, 1'b0);
  endtask

  task automatic wr(input logic [DATA_W-1:0] d);
    @(negedge CLOCK_50);
    sw_data = d;
    sb.push_back('{m_addr, d});
    m_addr = m_addr + 1'b1;
    hit(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    #4 reset = 1'b0;
    #18 reset = 1'b1;
    #1;
    chk("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_ld_we", 32'(ld_we), 32'd0);
    @(negedge CLOCK_50);
    chk("idle_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("idle_mode", 32'(mode), 32'd0);

    // Load entry with latency check.
    @(negedge CLOCK_50);
    key_load = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    chk("lat_early_mode", 32'(mode), 32'd0);
    @(negedge CLOCK_50);
    key_load = 1'b0;
    chk("load_mode", 32'(mode), 32'd1);
    chk("load_mem_sel", 32'(mem_sel), 32'd1);
    chk("load_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("load_cpu_en", 32'(cpu_en), 32'd0);
    m_addr = '0;
    wr(8'hA1);
    wr(8'h3C);
    wr(8'hFF);
    @(negedge CLOCK_50);
    chk("ld_addr_inc", 32'(ld_addr), 32'd3);
    hit(0);
    chk("unload_mode", 32'(mode), 32'd0);
    chk("unload_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("unload_mem_sel", 32'(mem_sel), 32'd0);
    chk("sb_empty1", 32'(sb.size()), 32'd0);

    // Address wrap.
    hit(0);
    chk("reload_addr", 32'(ld_addr), 32'd0);
    m_addr = '0;
    for (int i = 0; i < 33; i++) wr(8'(i * 7 + 1));
    @(negedge CLOCK_50);
    chk("sb_empty2", 32'(sb.size()), 32'd0);
    chk("wrap_addr", 32'(ld_addr), 32'd1);
    hit(0);
    chk("unload2_mode", 32'(mode), 32'd0);

    // Single step.
    fetch_state = 1'b1;
    hit(3);
    chk("step_leave_mode", 32'(mode), 32'd3);
    chk("step_leave_en", 32'(cpu_en), 32'd1);
    @(negedge CLOCK_50) fetch_state = 1'b0;
    @(negedge CLOCK_50);
    chk("step_wait_mode", 32'(mode), 32'd4);
    chk("step_wait_en", 32'(cpu_en), 32'd1);
    @(negedge CLOCK_50) fetch_state = 1'b1;
    @(negedge CLOCK_50);
    chk("step_done_mode", 32'(mode), 32'd0);
    chk("step_done_en", 32'(cpu_en), 32'd0);
    chk("step_count", 32'(instr_count), 32'd1);
    @(negedge CLOCK_50);
    chk("step_count_hold", 32'(instr_count), 32'd1);

    // Run, count two fetches.
    hit(2);
    chk("run_mode", 32'(mode), 32'd2);
    chk("run_en", 32'(cpu_en), 32'd1);
    @(negedge CLOCK_50) fetch_state = 1'b0;
    @(negedge CLOCK_50) fetch_state = 1'b1;
    @(negedge CLOCK_50) fetch_state = 1'b0;
    @(negedge CLOCK_50) fetch_state = 1'b1;
    @(negedge CLOCK_50);
    chk("run_count", 32'(instr_count), 32'd3);

    // Halt arrives in the same cycle as the start pulse.
    @(negedge CLOCK_50);
    key_start = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    Halt = 1'b1;
    @(negedge CLOCK_50);
    key_start = 1'b0;
    chk("halt_mode", 32'(mode), 32'd5);
    chk("halt_en", 32'(cpu_en), 32'd0);
    Halt = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("halt_hold_mode", 32'(mode), 32'd5);

    // Restart.
    hit(2);
    chk("restart_mode", 32'(mode), 32'd6);
    chk("restart_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("restart_count", 32'(instr_count), 32'd0);
    @(negedge CLOCK_50);
    chk("rerun_mode", 32'(mode), 32'd2);
    chk("rerun_rst_n", 32'(cpu_rst_n), 32'd1);
    chk("rerun_en", 32'(cpu_en), 32'd1);
    @(negedge CLOCK_50) fetch_state = 1'b0;
    @(negedge CLOCK_50) fetch_state = 1'b1;
    @(negedge CLOCK_50);
    chk("rerun_count", 32'(instr_count), 32'd1);
    hit(2);
    chk("pause_mode", 32'(mode), 32'd0);
    chk("pause_en", 32'(cpu_en), 32'd0);

    // Simultaneous keys in IDLE.
    @(negedge CLOCK_50);
    key_load = 1'b1; key_start = 1'b1; key_step = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    key_load = 1'b0; key_start = 1'b0; key_step = 1'b0;
    chk("simul_mode", 32'(mode), 32'd1);
    chk("simul_count", 32'(instr_count), 32'd0);
    chk("simul_mem_sel", 32'(mem_sel), 32'd1);
    repeat (3) @(negedge CLOCK_50);
    chk("simul_hold_mode", 32'(mode), 32'd1);

    // Asynchronous reset mid-operation.
    @(negedge CLOCK_50);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_mode", 32'(mode), 32'd0);
    chk("mid_rst_mem_sel", 32'(mem_sel), 32'd0);
    chk("mid_rst_rst_n", 32'(cpu_rst_n), 32'd0);
    #5 reset = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/load sequencer for the accumulator processor. It sits between the board keys/switches, the processor control unit and the program memory. It holds the control unit idle or in reset, lets the operator load a program through the switches, and runs either freely or one instruction per key press. It also counts executed instructions and reports Halt.

Parameters:
ADDR_W, 5, program memory address width
DATA_W, 8, program memory data width
CNT_W, 16, instruction counter width
DB_CYCLES, 500000, debounce stability window in clocks (used only with the optional feature)

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low; resets every register in the block
key_load  in  1  load-mode toggle key, active-high, asynchronous to the clock
key_write  in  1  write-word key, active-high, asynchronous
key_start  in  1  run/pause key, active-high, asynchronous
key_step  in  1  single-step key, active-high, asynchronous
sw_data  in  DATA_W  word to be written in LOAD
Halt  in  1  from the control unit
fetch_state  in  1  high while the control unit is in its fetch state
cpu_en  out  1  clock enable for the control unit and datapath
cpu_rst_n  out  1  active-low reset to the control unit
mem_sel  out  1  memory port owner: 0 = CPU, 1 = loader
ld_we  out  1  loader write strobe, one cycle per word
ld_addr  out  ADDR_W  loader write address
ld_data  out  DATA_W  loader write data
mode  out  3  current state code, for the 7-segment display
instr_count  out  CNT_W  completed instruction fetches

Behaviour:
- All outputs are registered.
- Values during reset: cpu_en=0, cpu_rst_n=0, mem_sel=0, ld_we=0, ld_addr=0, ld_data=0, mode=IDLE, instr_count=0.
- Key path: each key passes through a 2-FF synchroniser and then a rising-edge detector. A key held high produces exactly one pulse.
- Latency: if a key is first sampled high at edge N, its pulse acts at edge N+2, and the resulting output change is visible after edge N+3.
- Simultaneous key pulses: priority is load > start > step > write. Lower-priority pulses in the same cycle are dropped.
- States and codes: IDLE=0, LOAD=1, RUN=2, STEP_LEAVE=3, STEP_WAIT=4, HALTED=5, RESTART=6.
- IDLE: cpu_en=0, cpu_rst_n=1, mem_sel=0. The CPU state is preserved.
  - load -> LOAD
  - start -> RUN
  - step -> STEP_LEAVE
- LOAD: cpu_rst_n=0, cpu_en=0, mem_sel=1.
  - On entry: ld_addr=0 and instr_count=0.
  - write pulse: ld_we=1 for one cycle, with ld_data=sw_data and the current ld_addr. ld_addr increments in the following cycle and wraps from 2^ADDR_W-1 to 0.
  - load -> IDLE, with cpu_rst_n=1 from the next cycle.
- RUN: cpu_en=1.
  - Halt=1 -> HALTED. Halt takes priority over any key pulse in the same cycle.
  - start -> IDLE (pause).
- STEP_LEAVE: cpu_en=1. fetch_state=0 -> STEP_WAIT.
- STEP_WAIT: cpu_en=1.
  - fetch_state=1 -> IDLE; cpu_en drops so that exactly one instruction completes.
  - Halt=1 in either step state -> HALTED.
- HALTED: cpu_en=0.
  - load -> LOAD
  - start -> RESTART
- RESTART: cpu_rst_n=0 for exactly 1 cycle and instr_count=0, then -> RUN.
- instr_count: increments on each 0->1 transition of fetch_state while cpu_en=1. It saturates at 2^CNT_W-1.
- Keys other than those listed for a state are ignored in that state.
- Reset asserted mid-operation: the block returns immediately to IDLE with the reset values. Reset has no dependence on the clock.

Optional Feature:
KEY_DEBOUNCE_EN
- Defined: after the synchroniser, a key level is accepted only once it has been stable for DB_CYCLES consecutive clocks. The edge is taken on the accepted level, so latency becomes N+2+DB_CYCLES.
- Undefined: no debounce; synchroniser plus edge detector only. DB_CYCLES is unused.

Decomposition:
- Package cpu_run_pkg:
  - state encoding constants IDLE..RESTART (3 bits)
  - default widths ADDR_W/DATA_W/CNT_W
- Sub-module key_edge: synchroniser, optional debounce and rising-edge pulse. Instantiated 4 times.

Test Plan:
- Reset low at t=4, then high. Until the first clock after release: cpu_rst_n=0, cpu_en=0, mode=0, instr_count=0.
- Load: key_load pulse; then writes with sw_data=8'hA1, 8'h3C, 8'hFF; then key_load again. Required: three single-cycle ld_we at ld_addr 0,1,2 with matching data, then mode=0 and cpu_rst_n=1.
- Address wrap: 33 writes in LOAD with ADDR_W=5. The 33rd write has ld_addr=0.
- Single step: fetch_state toggles 1,0,0,1 across cycles. Required: cpu_en high from STEP_LEAVE until fetch_state returns to 1, then 0; instr_count increments by exactly 1.
- Run then halt: in RUN, Halt=1 asserted with key_start pulsed in the same cycle. Required: mode=5, cpu_en=0. A following key_start gives one cycle cpu_rst_n=0, instr_count=0, then mode=2.
- Simultaneous keys: key_load, key_start and key_step rise on the same edge in IDLE. Required: mode=1 only.
